// File: rtl/bcd_time_counter_pkg.sv
// Shared types and constants for the BCD time-of-day counter.
// Holds FSM states, BCD limits and load_data field offsets.
package bcd_time_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int S0_LSB = 0;
  localparam int S1_LSB = 4;
  localparam int M0_LSB = 8;
  localparam int M1_LSB = 12;
  localparam int H0_LSB = 16;
  localparam int H1_LSB = 20;

  function automatic logic bcd_time_ok(
    input logic [23:0] d
  );
    logic ok;
    ok = 1'b1;
    if (d[S0_LSB +: 4] > 4'd9) ok = 1'b0;
    if (d[S1_LSB +: 4] > 4'd5) ok = 1'b0;
    if (d[M0_LSB +: 4] > 4'd9) ok = 1'b0;
    if (d[M1_LSB +: 4] > 4'd5) ok = 1'b0;
    if (d[H0_LSB +: 4] > 4'd9) ok = 1'b0;
    if (d[H1_LSB +: 4] > 4'd9) ok = 1'b0;
    // digits already checked, so byte compare is a true BCD compare
    if (d[H0_LSB +: 8] > HOUR_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_time_counter_mod.sv
// Two-digit BCD modulo counter with load and carry-out.
// Digits increment individually; wraps to 00 after MAX_BCD.
module bcd_mod_counter #(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic       carry_out
);

  logic [7:0] nxt;

  always_comb begin
    nxt = val;
    if (val == MAX_BCD)
      nxt = 8'h00;
    else if (val[3:0] == 4'd9)
      nxt = {val[7:4] + 4'd1, 4'd0};
    else
      nxt = {val[7:4], val[3:0] + 4'd1};
  end

  assign carry_out = inc & (val == MAX_BCD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      val <= 8'h00;
    else if (load)
      val <= load_val;
    else if (inc)
      val <= nxt;
  end

endmodule

// File: rtl/bcd_time_counter.sv
// Time-of-day stage: syncs slow_clk, prescales edges, counts HH:MM:SS.
// Time-set loads arrive over valid/ready and are checked in APPLY.
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int unsigned EDGES_PER_SEC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        slow_clk,
  input  logic        run,
  input  logic        load_valid,
  input  logic [23:0] load_data,
  output logic        load_ready,
  output logic        load_err,
  output logic [7:0]  hh,
  output logic [7:0]  mm,
  output logic [7:0]  ss,
  output logic        sec_pulse,
  output logic        rollover
);

  localparam logic [7:0] PRESC_TOP =
    8'(EDGES_PER_SEC - 32'd1);

  logic        sync1, sync2, sync3;
  logic [1:0]  fill;
  logic        armed;
  logic        tick, tick_r, pend;
  logic [7:0]  presc;
  logic [23:0] load_buf;
  state_t      state, state_nxt;
  logic        accept, in_apply, data_ok;
  logic        do_load, cnt_tick, sec_adv;
  logic        ss_c, mm_c, hh_c;

  // armed blocks a level seen high right after reset from
  // being taken as a rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      fill   <= 2'd0;
      armed  <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      sync1  <= slow_clk;
      sync2  <= sync1;
      sync3  <= sync2;
      tick_r <= tick;
      if (fill != 2'd2)
        fill <= fill + 2'd1;
      if (fill == 2'd2 && !sync2)
        armed <= 1'b1;
    end
  end

  assign tick = sync2 & ~sync3 & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = run ? COUNT : IDLE;
    unique case (state)
      IDLE, COUNT:
        if (accept) state_nxt = APPLY;
      APPLY: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state != APPLY);
    in_apply   = (state == APPLY);
  end

  assign accept  = load_valid & load_ready;
  assign data_ok = bcd_time_ok(load_buf);
  assign do_load = in_apply & data_ok;

  // a tick landing on the accept cycle waits in pend until
  // the load is judged
  always_comb begin
    cnt_tick = 1'b0;
    unique case (1'b1)
      in_apply: cnt_tick = run & ~data_ok & (tick_r | pend);
      accept:   cnt_tick = 1'b0;
      default:  cnt_tick = run & tick_r;
    endcase
  end

  assign sec_adv = cnt_tick & (presc == PRESC_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= 8'd0;
      pend      <= 1'b0;
      load_buf  <= 24'd0;
      load_err  <= 1'b0;
      sec_pulse <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      pend      <= accept & tick_r;
      load_err  <= in_apply & ~data_ok;
      sec_pulse <= sec_adv;
      rollover  <= hh_c;
      if (accept)
        load_buf <= load_data;
      if (do_load)
        presc <= 8'd0;
      else if (cnt_tick)
        presc <= (presc == PRESC_TOP) ? 8'd0 : presc + 8'd1;
    end
  end

  bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_ss (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (sec_adv),
    .load      (do_load),
    .load_val  (load_buf[S0_LSB +: 8]),
    .val       (ss),
    .carry_out (ss_c)
  );

  bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_mm (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ss_c),
    .load      (do_load),
    .load_val  (load_buf[M0_LSB +: 8]),
    .val       (mm),
    .carry_out (mm_c)
  );

  bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hh (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (mm_c),
    .load      (do_load),
    .load_val  (load_buf[H0_LSB +: 8]),
    .val       (hh),
    .carry_out (hh_c)
  );

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter.
// Two instances: one edge per second and four edges per second.
module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        rst_n, slow_clk, run, load_valid;
  logic [23:0] load_data;
  logic        load_ready, load_err, sec_pulse, rollover;
  logic [7:0]  hh, mm, ss;
  logic        r4, e4, sp4, ro4;
  logic [7:0]  hh4, mm4, ss4;

  int n_cmp = 0;
  int n_bad = 0;
  int sp_cnt, sp_at, ro_cnt, ro_solo, sp4_cnt, err_cnt;

  always #5 clk = ~clk;

  bcd_time_counter #(.EDGES_PER_SEC(1)) u1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .slow_clk   (slow_clk),
    .run        (run),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_err   (load_err),
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .sec_pulse  (sec_pulse),
    .rollover   (rollover)
  );

  bcd_time_counter #(.EDGES_PER_SEC(4)) u4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .slow_clk   (slow_clk),
    .run        (run),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (r4),
    .load_err   (e4),
    .hh         (hh4),
    .mm         (mm4),
    .ss         (ss4),
    .sec_pulse  (sp4),
    .rollover   (ro4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int idx);
    @(negedge clk);
    if (sec_pulse) begin
      sp_cnt++;
      if (sp_at < 0) sp_at = idx;
    end
    if (rollover) begin
      ro_cnt++;
      if (!sec_pulse) ro_solo++;
    end
    if (sp4) sp4_cnt++;
    if (load_err) err_cnt++;
  endtask

  task automatic slow_period(input int hi, input int lo);
    sp_at = -1;
    slow_clk = 1'b1;
    for (int i = 1; i <= hi; i++) cyc(i);
    slow_clk = 1'b0;
    for (int i = 1; i <= lo; i++) cyc(hi + i);
  endtask

  task automatic do_load(input logic [23:0] d);
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk);
    cyc(0);
    chk("ready_apply", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    cyc(0);
    chk("ready_back", {31'd0, load_ready}, 32'd1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    cyc(0);
    rst_n = 1'b1;
    repeat (5) cyc(0);
  endtask

  initial begin
    rst_n = 1'b0; slow_clk = 1'b0; run = 1'b0;
    load_valid = 1'b0; load_data = 24'd0;
    sp_cnt = 0; sp_at = -1; ro_cnt = 0; ro_solo = 0;
    sp4_cnt = 0; err_cnt = 0;
    #12;
    chk("rst_time", {8'd0, hh, mm, ss}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    chk("rst_sp", {31'd0, sec_pulse}, 32'd0);
    chk("rst_ro", {31'd0, rollover}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc(0);

    // three seconds at one edge per second
    run = 1'b1; sp_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      slow_period(6, 6);
      chk("t1_latency", sp_at, 32'd4);
    end
    chk("t1_ss", {24'd0, ss}, 32'h03);
    chk("t1_pulses", sp_cnt, 32'd3);

    // rollover through midnight
    err_cnt = 0; ro_cnt = 0; ro_solo = 0;
    do_load(24'h235958);
    cyc(0);
    chk("t2_err", err_cnt, 32'd0);
    chk("t2_load", {8'd0, hh, mm, ss}, 32'h235958);
    slow_period(6, 6);
    chk("t2_59", {8'd0, hh, mm, ss}, 32'h235959);
    chk("t2_no_ro", ro_cnt, 32'd0);
    slow_period(6, 6);
    chk("t2_wrap", {8'd0, hh, mm, ss}, 32'h000000);
    chk("t2_ro_cnt", ro_cnt, 32'd1);
    chk("t2_ro_with_sp", ro_solo, 32'd0);

    // out-of-range loads
    err_cnt = 0;
    do_load(24'h126100);
    cyc(0);
    chk("t3_err_m1", err_cnt, 32'd1);
    chk("t3_keep", {8'd0, hh, mm, ss}, 32'h000000);
    err_cnt = 0;
    do_load(24'h240000);
    cyc(0);
    chk("t3_err_h24", err_cnt, 32'd1);
    err_cnt = 0;
    do_load(24'h1A0000);
    cyc(0);
    chk("t3_err_digit", err_cnt, 32'd1);
    chk("t3_keep2", {8'd0, hh, mm, ss}, 32'h000000);

    // four edges per second with a run gap
    rst_pulse();
    run = 1'b1; sp4_cnt = 0;
    slow_period(6, 6);
    slow_period(6, 6);
    chk("t4_two", {24'd0, ss4}, 32'h00);
    run = 1'b0;
    for (int p = 0; p < 5; p++) slow_period(6, 6);
    chk("t4_hold", {24'd0, ss4}, 32'h00);
    chk("t4_hold_sp", sp4_cnt, 32'd0);
    run = 1'b1;
    slow_period(6, 6);
    chk("t4_three", {24'd0, ss4}, 32'h00);
    slow_period(6, 6);
    chk("t4_four", {24'd0, ss4}, 32'h01);
    chk("t4_sp", sp4_cnt, 32'd1);

    // tick on the accept cycle of a valid load, then back-to-back
    sp_cnt = 0; err_cnt = 0;
    slow_clk = 1'b1;
    cyc(1); cyc(2); cyc(3);
    load_valid = 1'b1;
    load_data  = 24'h100000;
    @(posedge clk);
    cyc(4);
    chk("t5_ready_a", {31'd0, load_ready}, 32'd0);
    cyc(5);
    chk("t5_time", {8'd0, hh, mm, ss}, 32'h100000);
    chk("t5_ready_a1", {31'd0, load_ready}, 32'd1);
    load_data = 24'h113000;
    cyc(6);
    chk("t5_b2b", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    cyc(7);
    chk("t5_time2", {8'd0, hh, mm, ss}, 32'h113000);
    chk("t5_no_sp", sp_cnt, 32'd0);
    slow_clk = 1'b0;
    repeat (6) cyc(0);

    // tick on the accept cycle of an invalid load is kept
    sp_cnt = 0; err_cnt = 0;
    slow_clk = 1'b1;
    cyc(1); cyc(2); cyc(3);
    load_valid = 1'b1;
    load_data  = 24'h116000;
    @(posedge clk);
    cyc(4);
    load_valid = 1'b0;
    cyc(5);
    chk("t5b_time", {8'd0, hh, mm, ss}, 32'h113001);
    chk("t5b_sp", sp_cnt, 32'd1);
    chk("t5b_err", err_cnt, 32'd1);
    slow_clk = 1'b0;
    repeat (6) cyc(0);

    // asynchronous reset mid-count, slow_clk high on release
    do_load(24'h050709);
    cyc(0);
    chk("t6_load", {8'd0, hh, mm, ss}, 32'h050709);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async", {8'd0, hh, mm, ss}, 32'h000000);
    chk("t6_ready", {31'd0, load_ready}, 32'd1);
    slow_clk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    sp_cnt = 0;
    repeat (10) cyc(0);
    chk("t6_no_stale", sp_cnt, 32'd0);
    chk("t6_ss0", {24'd0, ss}, 32'h00);
    slow_clk = 1'b0;
    repeat (6) cyc(0);
    slow_period(6, 6);
    chk("t6_fresh", {24'd0, ss}, 32'h01);
    chk("t6_fresh_sp", sp_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Timekeeping stage fed by the slow square-wave output of the clock divider. Synchronises that wave into the system clock domain and detects its rising edges. Counts the edges into a 24-hour BCD time of day (HH:MM:SS). Accepts time-set commands from a processor port over a valid/ready handshake, and drives the 7-segment display logic and the processor input ports.

## Interface
- EDGES_PER_SEC, default 1: rising edges of `slow_clk` per second increment; range 1..255.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- slow_clk  in  1  divider square wave; treated as asynchronous, with high and low phases each ≥3 clk.
- run  in  1  count enable; level, synchronous.
- load_valid  in  1  time-set request.
- load_data  in  24  BCD {H1,H0,M1,M0,S1,S0}, 4 bits each, H1 in MSBs.
- load_ready  out  1  port can accept a load this cycle.
- load_err  out  1  one-cycle pulse: accepted load was out of range.
- hh, mm, ss  out  8 each  current time in BCD.
- sec_pulse  out  1  one-cycle pulse when `ss` increments.
- rollover  out  1  one-cycle pulse on 23:59:59 → 00:00:00.

## Operation
- Synchroniser: two flops on `slow_clk`, then a third flop for edge detection; `tick` = sync2 & ~sync3.
- Prescaler (8 bit): counts ticks while `run`=1. At EDGES_PER_SEC-1 it wraps to 0 and the time advances by one second.
- While `run`=0, ticks are discarded and the prescaler holds its value. The synchroniser keeps running so no stale edge is seen on re-enable.
- Increment: ss 00..59. Carry → mm 00..59. Carry → hh 00..23. Carry → 00:00:00 with `rollover`.
- Each BCD pair increments per digit: the low digit wraps 9→0 with carry into the high digit; no binary add followed by conversion.
- States:
  - IDLE (run=0): `load_ready`=1.
  - COUNT (run=1): `load_ready`=1.
  - APPLY: one cycle after load acceptance, `load_ready`=0; returns to IDLE or COUNT from `run`.
- Load is accepted when `load_valid`&`load_ready`, and `load_data` is captured on that edge. In APPLY the data is validated:
  - each digit ≤9, S1≤5, M1≤5, hh≤23 → time := data, prescaler := 0;
  - otherwise the time is unchanged, `load_err` pulses, and the prescaler is untouched.
- Tick during APPLY or on the accept cycle: discarded when the load is valid; counted normally when the load is invalid.
- `run` change mid-second: prescaler retained; no partial-second loss.

## Timing
- Reset values: hh=mm=ss=8'h00, prescaler 0, synchroniser flops 0, state IDLE, `load_ready`=1, `load_err`=`sec_pulse`=`rollover`=0.
- Reset asserted mid-operation clears everything immediately, independent of clk. The first tick after release needs a fresh rising edge of `slow_clk`.
- `slow_clk` rising edge first sampled at clk edge N → `tick` high in cycle N+2 → `ss`, `sec_pulse` (and `rollover`) update/pulse at edge N+3 when the prescaler wraps.
- Load accepted at edge A → APPLY during A..A+1 → time or `load_err` visible after edge A+1. `load_ready` is low for exactly that one cycle.
- Back-to-back loads: second acceptance no earlier than edge A+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - state enum {IDLE, COUNT, APPLY};
  - BCD limit constants (SEC_MAX 8'h59, MIN_MAX 8'h59, HOUR_MAX 8'h23);
  - field offsets of `load_data`.
- Sub-module `bcd_mod_counter` (parameter MAX_BCD): 8-bit BCD pair with `inc`, `load`, and `carry_out`. Instantiated three times (59, 59, 23).
- Synchroniser and edge detect stay inline.

## Test plan
- Reset, run=1, EDGES_PER_SEC=1, 3 slow_clk periods → ss=8'h03, three `sec_pulse`, each 3 clk after the sampled rising edge.
- Load 24'h235958 then 2 ticks → 23:59:59, then 00:00:00 with a single `rollover` pulse coincident with `sec_pulse`.
- Load 24'h126100 (M1=6) → `load_err` one cycle, time unchanged; load 24'h240000 → `load_err`; load 24'h1A0000 → `load_err`.
- EDGES_PER_SEC=4, 2 ticks, run=0 for 5 slow periods, run=1, 2 ticks → ss increments exactly once, at the fourth counted tick.
- Tick on the same cycle as a valid load of 24'h100000 → time reads 10:00:00 and no `sec_pulse`. Then `load_valid` held high → second acceptance exactly 2 cycles after the first.
- Reset asserted mid-count at 05:07:09 with no clk edge → outputs read 00:00:00 immediately. After release with `slow_clk` held high → no tick until the next rising edge.
